bcd_scan_mux: RTL and testbench

- Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display.
- Holds a packed multi-digit BCD value and presents one digit per scan slot on A/B/C/D (A = MSB) plus dp. These outputs feed the BCD-to-7-segment decoder directly, with a one-hot digit enable driving the digit commons.
- New values are double-buffered and applied only at frame boundaries, so a display frame never shows a mix of old and new digits.

---
 rtl/bcd_scan_mux.sv | 156 +++++++++++++++
 tb/tb_bcd_scan_mux.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_mux.sv
// ---------------------------------------------------------------------------
// bcd_scan_mux
//
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment
// display. A packed BCD value is held in a display register and one digit is
// presented per scan slot on A/B/C/D (A = MSB) together with its decimal
// point. A one-hot dig_en selects the digit common. New values are
// double-buffered: a load lands in a pending register and is only copied into
// the display register at a frame boundary, so a frame never mixes old and
// new digits.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        synchronous active-high reset
//   load       one-cycle strobe capturing digits_in / dp_in
//   digits_in  packed BCD, digit i at [4i+3:4i], digit 0 least significant
//   dp_in      decimal point per digit
//   blank_lz   live leading-zero blanking enable
//   A,B,C,D    current digit nibble (A = bit 3)
//   dp         decimal point of the current digit
//   dig_en     one-hot digit enable, all zero for a blanked slot
//   pend       a loaded value waits for the next frame boundary
//   err        displayed value holds a nibble greater than 9
// ---------------------------------------------------------------------------
module bcd_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  pend,
  output logic                  err
);

  localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PSC_W-1:0]    r_psc;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]   r_dispDp;
  logic [4*DIGITS-1:0] r_pnd;
  logic [DIGITS-1:0]   r_pndDp;
  logic                r_pend;
  logic                r_err;

  logic                w_pscWrap;
  logic                w_frameEnd;
  logic [3:0]          w_nibble;
  logic [DIGITS-1:0]   w_zeroFrom;
  logic                w_blank;

  // True when any BCD nibble of the value is outside 0..9.
  function automatic logic hasBadNibble(input logic [4*DIGITS-1:0] value);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // The frame boundary is the last cycle of the last digit slot; whatever is
  // written to the display on this edge is first seen in the idx = 0 slot.
  assign w_pscWrap  = (r_psc == PSC_LAST);
  assign w_frameEnd = w_pscWrap && (r_idx == IDX_LAST);

  // Scan counters: the prescaler sets the slot length, the digit index walks
  // the slots and wraps once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc <= '0;
      r_idx <= '0;
    end else begin
      if (w_pscWrap) begin
        r_psc <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_psc <= r_psc + 1'b1;
      end
    end
  end

  // Double buffer. A load at the frame boundary goes straight to the display
  // and discards anything pending, so the newest value always wins. The error
  // flag tracks the display register and only changes when it is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp   <= '0;
      r_dispDp <= '0;
      r_pnd    <= '0;
      r_pndDp  <= '0;
      r_pend   <= 1'b0;
      r_err    <= 1'b0;
    end else if (load && w_frameEnd) begin
      r_disp   <= digits_in;
      r_dispDp <= dp_in;
      r_pend   <= 1'b0;
      r_err    <= hasBadNibble(digits_in);
    end else if (load) begin
      r_pnd    <= digits_in;
      r_pndDp  <= dp_in;
      r_pend   <= 1'b1;
    end else if (w_frameEnd && r_pend) begin
      r_disp   <= r_pnd;
      r_dispDp <= r_pndDp;
      r_pend   <= 1'b0;
      r_err    <= hasBadNibble(r_pnd);
    end
  end

  // w_zeroFrom[i] is set when digit i and every more significant digit are
  // zero with no decimal point lit; such digits are leading zeros.
  always_comb begin
    logic run;
    run        = 1'b1;
    w_zeroFrom = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run           = run & (r_disp[4*i +: 4] == 4'd0) & ~r_dispDp[i];
      w_zeroFrom[i] = run;
    end
  end

  // Slot decode from registered state; blank_lz is the only input that reaches
  // the outputs combinationally. Digit 0 is never blanked so a zero value
  // still shows a single 0.
  always_comb begin
    w_nibble = r_disp[{r_idx, 2'b00} +: 4];
    w_blank  = blank_lz && (r_idx != '0) && w_zeroFrom[r_idx];
    if (w_blank) begin
      dig_en       = '0;
      {A, B, C, D} = 4'd0;
      dp           = 1'b0;
    end else begin
      dig_en       = DIGITS'(1) << r_idx;
      {A, B, C, D} = w_nibble;
      dp           = r_dispDp[r_idx];
    end
  end

  assign pend = r_pend;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_mux
//
// Bench for bcd_scan_mux with DIGITS = 4, SCAN_DIV = 4. A behavioural model
// tracks cycles since reset, the shown digits and the pending digits as plain
// integers; the display slot is derived arithmetically from the cycle count.
// One process compares every output against the model each cycle, and the
// directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_bcd_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic                clk;
  logic                rst;
  logic                load;
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic                blank_lz;
  logic                A, B, C, D, dp;
  logic [DIGITS-1:0]   dig_en;
  logic                pend;
  logic                err;
  logic [3:0]          abcd;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: digits as integers, cycle count since the last reset.
  int                mDisp[DIGITS];
  int                mPnd[DIGITS];
  logic [DIGITS-1:0] mDispDp;
  logic [DIGITS-1:0] mPndDp;
  bit                mPend;
  int                mCyc;
  bit                mValid = 1'b0;

  assign abcd = {A, B, C, D};

  bcd_scan_mux #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .dp        (dp),
    .dig_en    (dig_en),
    .pend      (pend),
    .err       (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired, got %0d vectors, expected completion", vectors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit zeroFrom(input int k);
    for (int j = k; j < DIGITS; j++) begin
      if (mDisp[j] != 0 || mDispDp[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Model update on each rising edge, then comparison of all outputs 1 time
  // unit later against what the rules say the current slot must show.
  always @(posedge clk) begin
    bit fb;
    int slot;
    bit blanked;
    logic [31:0] expEn, expNib, expDp, expErr;
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        mDisp[i] = 0;
        mPnd[i]  = 0;
      end
      mDispDp = '0;
      mPndDp  = '0;
      mPend   = 1'b0;
      mCyc    = 0;
      mValid  = 1'b1;
    end else if (mValid) begin
      fb = ((mCyc % FRAME) == FRAME - 1);
      if (load && fb) begin
        for (int i = 0; i < DIGITS; i++) mDisp[i] = int'(digits_in[4*i +: 4]);
        mDispDp = dp_in;
        mPend   = 1'b0;
      end else if (load) begin
        for (int i = 0; i < DIGITS; i++) mPnd[i] = int'(digits_in[4*i +: 4]);
        mPndDp = dp_in;
        mPend  = 1'b1;
      end else if (fb && mPend) begin
        for (int i = 0; i < DIGITS; i++) mDisp[i] = mPnd[i];
        mDispDp = mPndDp;
        mPend   = 1'b0;
      end
      mCyc++;
    end
    #1;
    if (mValid) begin
      slot    = (mCyc % FRAME) / SCAN_DIV;
      blanked = blank_lz && (slot > 0) && zeroFrom(slot);
      expEn   = blanked ? 0 : (32'd1 << slot);
      expNib  = blanked ? 0 : mDisp[slot];
      expDp   = blanked ? 0 : 32'(mDispDp[slot]);
      expErr  = 0;
      for (int j = 0; j < DIGITS; j++) if (mDisp[j] > 9) expErr = 1;
      checkOutput("dig_en", 32'(dig_en), expEn);
      checkOutput("ABCD", 32'(abcd), expNib);
      checkOutput("dp", 32'(dp), expDp);
      checkOutput("pend", 32'(pend), 32'(mPend));
      checkOutput("err", 32'(err), expErr);
    end
  end

  // Advance at falling edges until the model is at the requested frame phase.
  task automatic waitPhase(input int ph);
    int n;
    n = 0;
    while ((mCyc % FRAME) != ph) begin
      @(negedge clk);
      n++;
      if (n > 4 * FRAME) begin
        miscompares++;
        $display("[TB] FAIL waitPhase: got no phase %0d after %0d cycles, expected it within %0d", ph, n, 4 * FRAME);
        return;
      end
    end
  endtask

  // One-cycle load strobe, applied at a falling edge.
  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dps);
    load      = 1'b1;
    digits_in = value;
    dp_in     = dps;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blank_lz  = 1'b0;

    // Reset held two cycles, then the scan walks the four slots.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("pin reset dig_en", 32'(dig_en), 32'h1);
    checkOutput("pin reset ABCD", 32'(abcd), 32'h0);
    checkOutput("pin reset pend", 32'(pend), 32'h0);
    checkOutput("pin reset err", 32'(err), 32'h0);
    waitPhase(4);  checkOutput("pin scan slot1", 32'(dig_en), 32'h2);
    waitPhase(8);  checkOutput("pin scan slot2", 32'(dig_en), 32'h4);
    waitPhase(12); checkOutput("pin scan slot3", 32'(dig_en), 32'h8);
    waitPhase(0);  checkOutput("pin scan wrap", 32'(dig_en), 32'h1);

    // Mid-frame load waits for the boundary.
    waitPhase(5);
    applyStimulus(16'h1234, 4'b0100);
    checkOutput("pin midload pend", 32'(pend), 32'h1);
    waitPhase(0);
    checkOutput("pin midload d0", 32'(abcd), 32'h4);
    checkOutput("pin midload pend clr", 32'(pend), 32'h0);
    waitPhase(8);
    checkOutput("pin midload d2", 32'(abcd), 32'h2);
    checkOutput("pin midload dp2", 32'(dp), 32'h1);
    waitPhase(12);
    checkOutput("pin midload d3", 32'(abcd), 32'h1);
    checkOutput("pin midload dp3", 32'(dp), 32'h0);

    // Last load wins, then a load exactly at the boundary bypasses the buffer.
    waitPhase(2);  applyStimulus(16'h1111, 4'b0000);
    waitPhase(6);  applyStimulus(16'h2222, 4'b0000);
    waitPhase(0);  checkOutput("pin lastwins d0", 32'(abcd), 32'h2);
    waitPhase(15); applyStimulus(16'h5678, 4'b0000);
    checkOutput("pin bypass d0", 32'(abcd), 32'h8);
    checkOutput("pin bypass pend", 32'(pend), 32'h0);
    waitPhase(4);  checkOutput("pin bypass d1", 32'(abcd), 32'h7);

    // Leading-zero blanking on 0x0070.
    blank_lz = 1'b1;
    waitPhase(3);  applyStimulus(16'h0070, 4'b0000);
    waitPhase(0);
    checkOutput("pin lz d0 en", 32'(dig_en), 32'h1);
    checkOutput("pin lz d0", 32'(abcd), 32'h0);
    waitPhase(4);
    checkOutput("pin lz d1 en", 32'(dig_en), 32'h2);
    checkOutput("pin lz d1", 32'(abcd), 32'h7);
    waitPhase(8);  checkOutput("pin lz d2 en", 32'(dig_en), 32'h0);
    waitPhase(12); checkOutput("pin lz d3 en", 32'(dig_en), 32'h0);
    blank_lz = 1'b0;
    #1 checkOutput("pin lz off d3 en", 32'(dig_en), 32'h8);
    waitPhase(8);  checkOutput("pin lz off d2 en", 32'(dig_en), 32'h4);

    // Invalid BCD raises err and is still driven unmodified.
    waitPhase(1);  applyStimulus(16'h00A3, 4'b0000);
    waitPhase(0);  checkOutput("pin bad err", 32'(err), 32'h1);
    waitPhase(4);  checkOutput("pin bad d1", 32'(abcd), 32'hA);
    waitPhase(5);  applyStimulus(16'h0003, 4'b0000);
    checkOutput("pin bad err held", 32'(err), 32'h1);
    waitPhase(0);
    checkOutput("pin good err", 32'(err), 32'h0);
    checkOutput("pin good d0", 32'(abcd), 32'h3);

    // Reset mid-frame with a value pending and a simultaneous load.
    waitPhase(3);  applyStimulus(16'h4321, 4'b0000);
    waitPhase(9);
    rst       = 1'b1;
    load      = 1'b1;
    digits_in = 16'h9999;
    dp_in     = 4'b1111;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    checkOutput("pin rst dig_en", 32'(dig_en), 32'h1);
    checkOutput("pin rst ABCD", 32'(abcd), 32'h0);
    checkOutput("pin rst pend", 32'(pend), 32'h0);
    checkOutput("pin rst dp", 32'(dp), 32'h0);
    repeat (FRAME) @(negedge clk);
    checkOutput("pin rst after frame ABCD", 32'(abcd), 32'h0);
    checkOutput("pin rst after frame pend", 32'(pend), 32'h0);
    waitPhase(12);
    checkOutput("pin rst d3", 32'(abcd), 32'h0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < DIGITS; k++) begin
        case ($urandom_range(0, 7))
          0:       v[4*k +: 4] = 4'($urandom_range(10, 15));
          1, 2:    v[4*k +: 4] = 4'd0;
          default: v[4*k +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      load      = ($urandom_range(0, 7) == 0);
      digits_in = v;
      dp_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst       = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst  = 1'b0;
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
